// File: rtl/alpu_pkg.sv
// Shared ALU/FPU definitions: opcode boundaries, FPU-class decode, dispatch states.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package alpu_pkg;

  localparam int ALPU_OP_W = 5;

  // FPU-class opcode ranges; everything outside them executes on the ALU.
  localparam logic [ALPU_OP_W-1:0] OP_FPU_LO0_FIRST = 5'b01010;
  localparam logic [ALPU_OP_W-1:0] OP_FPU_LO0_LAST  = 5'b01101;
  localparam logic [ALPU_OP_W-1:0] OP_FPU_HI_FIRST  = 5'b10001;
  localparam logic [ALPU_OP_W-1:0] OP_FCLASS        = 5'b11000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } dispatch_state_t;

  // Also used by the result merge, so keep it free of any dispatch state.
  function automatic logic is_fpu_op(input logic [ALPU_OP_W-1:0] op);
    return ((op >= OP_FPU_LO0_FIRST) && (op <= OP_FPU_LO0_LAST)) ||
           (op >= OP_FPU_HI_FIRST);
  endfunction

endpackage

// File: rtl/alpu_timeout_cnt.sv
// Clear/enable up-counter with a terminal-count flag at MAX-1.
// Latency: o_tc is combinational from the registered count.
// Backpressure: none; clear has priority over enable.
module alpu_timeout_cnt #(
  parameter int MAX = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = (MAX > 2) ? $clog2(MAX) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(MAX - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_en && (cnt != TC_VAL)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_tc = (cnt == TC_VAL);

endmodule

// File: rtl/alpu_fpu_dispatch.sv
// Execute-stage FPU dispatch: decodes op, launches the multi-cycle FPU, stalls until done.
// Latency: accept -> ISSUE -> (WAIT)* -> DONE; 3 cycles minimum, stall high 2 of them.
// Backpressure: o_stall holds IF/ID/EX while an FPU op is in flight or refused (DRAIN).
// Ports: i_valid/i_alu_op/i_rs1_data/i_rs2_data/i_flush from EX; o_stall to the pipeline;
//        o_fpu_start/op/a/b and i_fpu_done/result to the FPU; o_fpu_sel/data/result_valid
//        to the result merge; o_timeout_err sticky until reset.
module alpu_fpu_dispatch
  import alpu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int OP_W        = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [OP_W-1:0]   i_alu_op,
  input  logic [DATA_W-1:0] i_rs1_data,
  input  logic [DATA_W-1:0] i_rs2_data,
  input  logic              i_flush,
  output logic              o_stall,
  output logic              o_fpu_start,
  output logic [OP_W-1:0]   o_fpu_op,
  output logic [DATA_W-1:0] o_fpu_a,
  output logic [DATA_W-1:0] o_fpu_b,
  input  logic              i_fpu_done,
  input  logic [DATA_W-1:0] i_fpu_result,
  output logic              o_fpu_sel,
  output logic [DATA_W-1:0] o_fpu_data,
  output logic              o_result_valid,
  output logic              o_timeout_err
);

  dispatch_state_t state, state_n;

  logic fpu_req;
  logic lat, cap, set_err;
  logic cnt_clr, cnt_en, cnt_tc;

  assign fpu_req = i_valid && is_fpu_op(i_alu_op) && !i_flush;

  alpu_timeout_cnt #(.MAX(TIMEOUT_CYC)) u_tmo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (cnt_clr),
    .i_en    (cnt_en),
    .o_tc    (cnt_tc)
  );

  always_comb begin
    state_n        = state;
    o_stall        = 1'b0;
    o_fpu_start    = 1'b0;
    o_fpu_sel      = 1'b0;
    o_result_valid = 1'b0;
    lat            = 1'b0;
    cap            = 1'b0;
    set_err        = 1'b0;
    cnt_clr        = 1'b0;
    cnt_en         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (fpu_req) begin
          o_stall = 1'b1;
          lat     = 1'b1;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        o_stall     = 1'b1;
        o_fpu_start = (state == ST_ISSUE);
        cnt_clr     = (state == ST_ISSUE);
        cnt_en      = (state == ST_WAIT);
        if (i_fpu_done) begin
          // A flush racing the result discards it; the FPU is already idle.
          cap     = !i_flush;
          state_n = i_flush ? ST_IDLE : ST_DONE;
        end else if ((state == ST_WAIT) && cnt_tc) begin
          set_err = 1'b1;
          state_n = ST_IDLE;
        end else if (i_flush) begin
          // FPU cannot be cancelled; swallow its eventual done in DRAIN.
          state_n = ST_DRAIN;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_DONE: begin
        o_result_valid = !i_flush;
        o_fpu_sel      = !i_flush;
        state_n        = ST_IDLE;
      end
      ST_DRAIN: begin
        o_stall = fpu_req;
        cnt_en  = 1'b1;
        if (i_fpu_done) begin
          state_n = ST_IDLE;
        end else if (cnt_tc) begin
          set_err = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      o_fpu_op      <= '0;
      o_fpu_a       <= '0;
      o_fpu_b       <= '0;
      o_fpu_data    <= '0;
      o_timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      if (lat) begin
        o_fpu_op <= i_alu_op;
        o_fpu_a  <= i_rs1_data;
        o_fpu_b  <= i_rs2_data;
      end
      if (cap) begin
        o_fpu_data <= i_fpu_result;
      end
      if (set_err) begin
        o_timeout_err <= 1'b1;
      end
    end
  end

endmodule
